// File: rtl/spi_master_pkg.sv
// Shared types and defaults for the SPI initiator.
//   state_e      : 3-bit FSM state encoding
//   DEF_NBITS    : default packet width
//   DEF_CLK_DIV  : default SCLK half-period in clk cycles
package spi_master_pkg;

  localparam int DEF_NBITS   = 34;
  localparam int DEF_CLK_DIV = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LEAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_TRAIL    = 3'd4,
    ST_RESP     = 3'd5,
    ST_GAP      = 3'd6
  } state_e;

endpackage

// File: rtl/spi_master_xfer_if.sv
// Request/response streams plus SPI pins of the initiator.
//   recv_*  : request word stream into the initiator
//   send_*  : captured word stream out of the initiator
//   spi_*   : minion-side pins (cs active-low, mode 0)
// master modport is the initiator's view; slave is the environment's view.
interface spi_master_xfer_if
  import spi_master_pkg::*;
#(
  parameter int NBITS = DEF_NBITS
);
  logic             recv_val;
  logic             recv_rdy;
  logic [NBITS-1:0] recv_msg;
  logic             send_val;
  logic             send_rdy;
  logic [NBITS-1:0] send_msg;
  logic             spi_cs;
  logic             spi_sclk;
  logic             spi_mosi;
  logic             spi_miso;

  modport master (
    input  recv_val, recv_msg, send_rdy, spi_miso,
    output recv_rdy, send_val, send_msg, spi_cs, spi_sclk, spi_mosi
  );

  modport slave (
    output recv_val, recv_msg, send_rdy, spi_miso,
    input  recv_rdy, send_val, send_msg, spi_cs, spi_sclk, spi_mosi
  );

endinterface

// File: rtl/spi_master_tick.sv
// Phase timer: a down-counter that reloads to CLK_DIV-1 on load_i or on
// reaching zero. tick_o is high on the last cycle of each CLK_DIV-cycle phase.
//   clk, reset_n : clock and asynchronous active-low reset
//   load_i       : restart the phase on the next cycle
//   tick_o       : last cycle of the current phase
module spi_master_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Free-running reload on terminal count lets consecutive phases chain
  // without the FSM having to reload explicitly.
  always_comb begin
    cnt_d = cnt_q - CW'(1);
    if (load_i || (cnt_q == '0)) cnt_d = LOAD_VAL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= LOAD_VAL;
    else          cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master_xfer.sv
// SPI mode-0 initiator: accepts a word on the recv stream, shifts it out
// MSB-first on MOSI while capturing MISO, then offers the captured word on
// the send stream.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus          : request/response streams and SPI pins (master modport)
//   busy         : high whenever the FSM is not in IDLE
//
// state    | meaning
// IDLE     | recv_rdy high, waiting for a request
// LEAD     | unused encoding; the first SHIFT_LO already gives cs-to-sclk setup
// SHIFT_LO | sclk low for CLK_DIV cycles, mosi holds current bit
// SHIFT_HI | sclk high for CLK_DIV cycles, miso sampled on the last one
// TRAIL    | cs still low, sclk low, mosi 0 for CLK_DIV cycles
// RESP     | cs high, send_val held until send_rdy
// GAP      | cs high for CLK_DIV cycles before accepting the next request
module spi_master_xfer
  import spi_master_pkg::*;
#(
  parameter int NBITS   = DEF_NBITS,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic                    clk,
  input  logic                    reset_n,
  spi_master_xfer_if.master       bus,
  output logic                    busy
);

  localparam int BCW = $clog2(NBITS + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(NBITS - 1);

  state_e           state_q;
  logic [NBITS-1:0] tx_q, tx_d;
  logic [NBITS-1:0] rx_q, rx_d;
  logic [BCW-1:0]   bit_cnt_q;
  logic             cs_q, sclk_q, send_val_q, recv_rdy_q, busy_q;

  logic recv_fire, send_fire, tick;

  // recv_rdy_q is only high in IDLE and send_val_q only in RESP, so these
  // handshakes are already qualified by state.
  assign recv_fire = bus.recv_val & recv_rdy_q;
  assign send_fire = send_val_q & bus.send_rdy;

  assign tx_d = {tx_q[NBITS-2:0], 1'b0};
  assign rx_d = {rx_q[NBITS-2:0], bus.spi_miso};

  spi_master_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (recv_fire | send_fire),
    .tick_o  (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      bit_cnt_q  <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      send_val_q <= 1'b0;
      recv_rdy_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (recv_fire) begin
            tx_q       <= bus.recv_msg;
            bit_cnt_q  <= '0;
            cs_q       <= 1'b0;
            recv_rdy_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          if (tick) begin
            sclk_q  <= 1'b1;
            state_q <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          // End of the high phase: sample, fall, and launch the next bit.
          // Zero-fill on the TX shift leaves mosi at 0 once all bits are out.
          if (tick) begin
            sclk_q    <= 1'b0;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            bit_cnt_q <= bit_cnt_q + BCW'(1);
            state_q   <= (bit_cnt_q == LAST_BIT) ? ST_TRAIL : ST_SHIFT_LO;
          end
        end
        ST_TRAIL: begin
          if (tick) begin
            cs_q       <= 1'b1;
            send_val_q <= 1'b1;
            state_q    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (send_fire) begin
            send_val_q <= 1'b0;
            state_q    <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tick) begin
            recv_rdy_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          cs_q       <= 1'b1;
          sclk_q     <= 1'b0;
          send_val_q <= 1'b0;
          recv_rdy_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.recv_rdy = recv_rdy_q;
  assign bus.send_val = send_val_q;
  assign bus.send_msg = rx_q;
  assign bus.spi_cs   = cs_q;
  assign bus.spi_sclk = sclk_q;
  assign bus.spi_mosi = tx_q[NBITS-1];
  assign busy         = busy_q;

endmodule
